// File: rtl/mem_responder.sv
// Unified instruction/data word RAM with one memory-mapped I/O word and a
// byte-serial program loader that holds the core in reset until loading completes.
module mem_responder #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] IO_ADDR    = 32'hFFFF_FFFC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_out,
    input  logic        data_wr,
    output logic [31:0] data_in,
    input  logic [7:0]  load_byte,
    input  logic        load_valid,
    output logic        load_ready,
    output logic        core_rst_n,
    output logic        load_done,
    input  logic [31:0] io_in,
    output logic [31:0] io_out
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        HDR,
        DATA,
        RUN
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [1:0]              lane;
    logic [23:0]             shift;
    logic [31:0]             count;
    logic [31:0]             widx;
    logic [31:0]             word;
    logic                    accept;
    logic                    last_byte;
    logic                    is_io;
    logic [ADDR_WIDTH-1:0]   inst_idx;
    logic [ADDR_WIDTH-1:0]   data_idx;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_idx;
    logic [31:0]             wr_data;
    logic [31:0]             mem [DEPTH];
    logic                    unused_addr_bits;

    assign unused_addr_bits = ^{inst_addr[31:ADDR_WIDTH+2], inst_addr[1:0]};

    assign inst_idx   = inst_addr[ADDR_WIDTH+1:2];
    assign data_idx   = data_addr[ADDR_WIDTH+1:2];
    assign is_io      = (data_addr == IO_ADDR);
    assign load_ready = (state == HDR) || (state == DATA);
    assign accept     = load_valid && load_ready;
    assign last_byte  = accept && (lane == 2'd3);
    assign word       = {shift, load_byte};

    // Asynchronous reads; a same-edge write is seen only from the next cycle.
    assign inst    = mem[inst_idx];
    assign data_in = is_io ? io_in : mem[data_idx];

    always_comb begin
        state_next = state;
        case (state)
            HDR: begin
                if (last_byte) begin
                    state_next = (word == 32'd0) ? RUN : DATA;
                end
            end
            DATA: begin
                if (last_byte && (widx + 32'd1 == count)) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // Single write port shared by the loader (DATA) and core stores (RUN);
    // reset suppresses both so a byte arriving with rst is dropped.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_data = '0;
        if (!rst) begin
            if (state == DATA && last_byte) begin
                wr_en   = 1'b1;
                wr_idx  = widx[ADDR_WIDTH-1:0];
                wr_data = word;
            end else if (state == RUN && data_wr && !is_io) begin
                wr_en   = 1'b1;
                wr_idx  = data_idx;
                wr_data = data_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            shift <= {shift[15:0], load_byte};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HDR;
            lane       <= 2'd0;
            count      <= 32'd0;
            widx       <= 32'd0;
            io_out     <= 32'd0;
            core_rst_n <= 1'b0;
            load_done  <= 1'b0;
        end else begin
            state      <= state_next;
            core_rst_n <= (state_next == RUN);
            load_done  <= (state_next == RUN);
            if (state_next != state) begin
                lane <= 2'd0;
            end else if (accept) begin
                lane <= lane + 2'd1;
            end
            if (state == HDR && last_byte) begin
                count <= word;
                widx  <= 32'd0;
            end
            if (state == DATA && last_byte) begin
                widx <= widx + 32'd1;
            end
            if (state == RUN && data_wr && is_io) begin
                io_out <= data_out;
            end
        end
    end

endmodule
